// File: rtl/gpu_sram_pkg.sv
// Shared types and widths for the frame-buffer SRAM arbiter.
// Imported by the interface, the arbiter and its testbench.
package gpu_sram_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 1536;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_F,
        OWN_A
    } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle of the arbiter.
// slave = arbiter view, master = environment (requesters + SRAM).
interface sram_arbiter_if;
    import gpu_sram_pkg::*;

    logic              init;

    logic              f_req;
    logic              f_we;
    logic [ADDR_W-1:0] f_address;
    logic [DATA_W-1:0] f_write_data;
    logic              f_gnt;
    logic              f_done;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_write_data;
    logic              a_gnt;
    logic              a_done;

    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0] read_data;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;

    modport slave (
        input  init,
        input  f_req, f_we, f_address, f_write_data,
        output f_gnt, f_done,
        input  a_req, a_we, a_address, a_write_data,
        output a_gnt, a_done,
        output rdata,
        input  read_data,
        output read_enable, write_enable, address, write_data
    );

    modport master (
        output init,
        output f_req, f_we, f_address, f_write_data,
        input  f_gnt, f_done,
        output a_req, a_we, a_address, a_write_data,
        input  a_gnt, a_done,
        input  rdata,
        output read_data,
        input  read_enable, write_enable, address, write_data
    );

endinterface

// File: rtl/sram_arbiter_flex_counter.sv
// Loadable down-counter with zero flag; times the SRAM access window.
// Saturates at zero so a stray decrement cannot wrap.
module flex_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one frame-buffer SRAM port between
// the fill unit (f) and the init/alpha unit (a).
module sram_arbiter
    import gpu_sram_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACC_CYCLES - 1);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              re_q;
    logic              wr_q;
    logic              f_gnt_q;
    logic              a_gnt_q;
    logic              f_done_q;
    logic              a_done_q;

    logic              f_elig;
    logic              a_elig;
    logic              win_f;
    logic              win_a;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    // init hides the fill unit; on a tie the previous owner yields
    assign f_elig = bus.f_req & ~bus.init;
    assign a_elig = bus.a_req;
    assign win_a  = a_elig & (~f_elig | (last_q == OWN_F));
    assign win_f  = f_elig & ~win_a;

    assign we_d    = win_a ? bus.a_we         : bus.f_we;
    assign addr_d  = win_a ? bus.a_address    : bus.f_address;
    assign wdata_d = win_a ? bus.a_write_data : bus.f_write_data;

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (state_q == IDLE) begin
            cnt_load = win_f | win_a;
        end
        if (state_q == ACCESS) begin
            cnt_dec = ~cnt_zero;
        end
    end

    flex_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_A;
            last_q   <= OWN_A;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            re_q     <= 1'b0;
            wr_q     <= 1'b0;
            f_gnt_q  <= 1'b0;
            a_gnt_q  <= 1'b0;
            f_done_q <= 1'b0;
            a_done_q <= 1'b0;
        end else begin
            f_gnt_q  <= 1'b0;
            a_gnt_q  <= 1'b0;
            f_done_q <= 1'b0;
            a_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_f | win_a) begin
                        owner_q <= win_a ? OWN_A : OWN_F;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        re_q    <= ~we_d;
                        wr_q    <= we_d;
                        f_gnt_q <= win_f;
                        a_gnt_q <= win_a;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (!we_q) begin
                            rdata_q <= bus.read_data;
                        end
                        last_q   <= owner_q;
                        re_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        f_done_q <= (owner_q == OWN_F);
                        a_done_q <= (owner_q == OWN_A);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.f_gnt        = f_gnt_q;
    assign bus.a_gnt        = a_gnt_q;
    assign bus.f_done       = f_done_q;
    assign bus.a_done       = a_done_q;
    assign bus.rdata        = rdata_q;
    assign bus.read_enable  = re_q;
    assign bus.write_enable = wr_q;
    assign bus.address      = addr_q;
    assign bus.write_data   = wdata_q;

endmodule
